// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants and the fetch packet type
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - imem request/response, redirect and decode handshake bundle
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    // Fetch stage side.
    modport master (
        output imem_req_valid, imem_addr, id_valid, id_instr, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    // Memory / execute / decode side.
    modport slave (
        input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, used for pc tags and fetch packets
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       wdata,
    output T                       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = DEPTH[CW-1:0];

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is legal when the head leaves the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner, imem request issue with credits, redirect flush
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_OUTST = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    localparam int CW = $clog2(MAX_OUTST) + 1;
    localparam logic [CW:0] MAX_C = MAX_OUTST[CW:0];

    logic             rst_n_q;
    logic [XLEN-1:0]  pc_q;
    logic [CW-1:0]    outst;
    logic [CW-1:0]    drop;
    logic [CW:0]      credit_sum;

    logic             redirect;
    logic             accept;
    logic             rsp;
    logic             rsp_keep;
    logic             id_fire;

    logic [XLEN-1:0]  tag_head;
    logic [CW-1:0]    tag_count;
    logic             tag_full;
    logic             tag_empty;

    fetch_pkt_t       pkt_in;
    fetch_pkt_t       pkt_head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign redirect   = bus.redirect_valid;
    assign credit_sum = {1'b0, outst} + {1'b0, fifo_count};

    // Requests in flight plus buffered packets never exceed the FIFO depth.
    assign bus.imem_req_valid = rst_n_q & ~redirect & (credit_sum < MAX_C);
    assign bus.imem_addr      = pc_q;
    assign accept             = bus.imem_req_valid & bus.imem_req_ready;

    // Responses with nothing outstanding (e.g. stragglers around reset) are ignored.
    assign rsp      = bus.imem_rsp_valid & (outst != '0);
    assign rsp_keep = rsp & (drop == '0) & ~redirect;

    assign pkt_in.instr = bus.imem_rdata;
    assign pkt_in.pc    = tag_head;

    assign bus.id_valid = ~fifo_empty;
    assign bus.id_instr = fifo_empty ? NOP_INSTR : pkt_head.instr;
    assign bus.id_pc    = fifo_empty ? '0 : pkt_head.pc;
    assign id_fire      = ~fifo_empty & bus.id_ready;

    fetch_fifo #(.DEPTH(MAX_OUTST), .T(logic [XLEN-1:0])) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (rsp_keep),
        .flush (redirect),
        .wdata (pc_q),
        .rdata (tag_head),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    fetch_fifo #(.DEPTH(MAX_OUTST), .T(fetch_pkt_t)) u_pkt_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_keep),
        .pop   (id_fire),
        .flush (redirect),
        .wdata (pkt_in),
        .rdata (pkt_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // PC, outstanding and drop counters; a redirect turns every in-flight request stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q <= 1'b0;
            pc_q    <= RESET_PC;
            outst   <= '0;
            drop    <= '0;
        end else begin
            rst_n_q <= 1'b1;
            if (redirect) begin
                pc_q  <= bus.redirect_pc & 32'hFFFF_FFFC;
                drop  <= outst - CW'(rsp);
                outst <= outst - CW'(rsp);
            end else begin
                if (accept) pc_q <= pc_q + 32'd4;
                if (rsp && (drop != '0)) drop <= drop - 1'b1;
                outst <= outst + CW'(accept) - CW'(rsp);
            end
        end
    end

    a_rsp_outst: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (outst != '0));
    a_tag_avail: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_keep |-> !tag_empty);
    a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> !tag_full);
    a_pkt_room: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_keep && fifo_full) |-> id_fire);
    a_tag_bal: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, tag_count} + {1'b0, drop}) == {1'b0, outst});

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized fetch stage bench with transaction-level reference model
module tb_fetch_stage;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if f();
    fetch_stage_if w();

    fetch_stage #(.RESET_PC(32'h0000_0000), .MAX_OUTST(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (f)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .MAX_OUTST(2)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    req_t        memq[$];
    fetch_pkt_t  expq[$];
    logic [31:0] acc_log[$];
    logic [31:0] dec_pc[$];
    logic [31:0] dec_ins[$];
    logic [31:0] dec_cyc[$];
    logic [31:0] wrap_log[$];

    logic [31:0] exp_pc = 32'h0;
    int          epoch = 0;
    bit          live = 1'b0;
    int          cyc = 0;
    int          stale_drops = 0;

    bit          rst_req = 1'b0;
    int unsigned ready_pct = 100;
    int unsigned idr_pct = 100;
    int unsigned rsp_pct = 100;
    int unsigned redir_pct = 0;
    bit          redir_force = 1'b0;
    logic [31:0] redir_target = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // One clock: drive at negedge, check outputs, advance the model to the coming posedge.
    task automatic step();
        bit         exp_req;
        bit         rv;
        req_t       r;
        fetch_pkt_t pk;
        @(negedge clk);
        rst_n = rst_req;
        f.imem_req_ready = ($urandom_range(0, 99) < ready_pct);
        f.id_ready       = ($urandom_range(0, 99) < idr_pct);
        f.redirect_valid = rst_req && live && (redir_force || ($urandom_range(0, 99) < redir_pct));
        f.redirect_pc    = redir_force ? redir_target : $urandom;
        rv = rst_req && (memq.size() > 0) && ($urandom_range(0, 99) < rsp_pct);
        f.imem_rsp_valid = rv;
        f.imem_rdata     = rv ? word_of(memq[0].addr) : $urandom;
        #1;
        exp_req = live && !f.redirect_valid && ((memq.size() + expq.size()) < 2);
        if (rst_req) begin
            check_val("req_valid", 32'(f.imem_req_valid), 32'(exp_req));
            if (exp_req) check_val("imem_addr", f.imem_addr, exp_pc);
            check_val("id_valid", 32'(f.id_valid), 32'(expq.size() != 0));
            if (expq.size() != 0) begin
                check_val("id_instr", f.id_instr, expq[0].instr);
                check_val("id_pc", f.id_pc, expq[0].pc);
            end
            if (w.imem_req_valid) wrap_log.push_back(w.imem_addr);
        end
        if (!rst_req) begin
            exp_pc = 32'h0;
            memq.delete();
            expq.delete();
            live = 1'b0;
        end else begin
            if (f.id_ready && expq.size() != 0) begin
                pk = expq.pop_front();
                dec_pc.push_back(pk.pc);
                dec_ins.push_back(pk.instr);
                dec_cyc.push_back(32'(cyc));
            end
            if (rv) begin
                r = memq.pop_front();
                if (!f.redirect_valid && r.epoch == epoch)
                    expq.push_back('{instr: word_of(r.addr), pc: r.addr});
                else
                    stale_drops++;
            end
            if (f.redirect_valid) begin
                expq.delete();
                epoch++;
                exp_pc = f.redirect_pc & 32'hFFFF_FFFC;
            end else if (exp_req && f.imem_req_ready) begin
                memq.push_back('{addr: exp_pc, epoch: epoch});
                acc_log.push_back(exp_pc);
                exp_pc += 32'd4;
            end
            live = 1'b1;
        end
        cyc++;
    endtask

    task automatic clear_logs();
        acc_log.delete();
        dec_pc.delete();
        dec_ins.delete();
        dec_cyc.delete();
    endtask

    initial begin
        int n;
        int d0;
        w.imem_req_ready = 1'b1;
        w.imem_rsp_valid = 1'b0;
        w.imem_rdata     = 32'h0;
        w.redirect_valid = 1'b0;
        w.redirect_pc    = 32'h0;
        w.id_ready       = 1'b0;

        rst_req = 1'b0;
        repeat (3) step();
        check_val("rst_id_valid", 32'(f.id_valid), 32'h0);
        check_val("rst_req_valid", 32'(f.imem_req_valid), 32'h0);
        check_val("rst_id_instr", f.id_instr, 32'h0000_0013);
        check_val("rst_id_pc", f.id_pc, 32'h0);

        rst_req = 1'b1;
        clear_logs();
        repeat (12) step();
        check_val("first_addr0", qget(acc_log, 0), 32'h0);
        check_val("first_addr1", qget(acc_log, 1), 32'h4);
        check_val("first_addr2", qget(acc_log, 2), 32'h8);
        check_val("stream_pc0", qget(dec_pc, 0), 32'h0);
        check_val("stream_pc1", qget(dec_pc, 1), 32'h4);
        check_val("stream_ins0", qget(dec_ins, 0), 32'h0050_0093);
        check_val("stream_ins1", qget(dec_ins, 1), 32'h00A0_0113);
        check_val("stream_gap", qget(dec_cyc, 1) - qget(dec_cyc, 0), 32'h1);
        check_val("wrap_addr0", qget(wrap_log, 0), 32'hFFFF_FFFC);
        check_val("wrap_addr1", qget(wrap_log, 1), 32'h0);

        redir_force = 1'b1; redir_target = 32'h40; step(); redir_force = 1'b0;
        idr_pct = 0;
        clear_logs();
        repeat (5) step();
        check_val("bp_accepts", 32'(acc_log.size()), 32'h2);
        check_val("bp_no_decode", 32'(dec_pc.size()), 32'h0);
        idr_pct = 100;
        repeat (8) step();
        check_val("bp_pc0", qget(dec_pc, 0), 32'h40);
        check_val("bp_pc1", qget(dec_pc, 1), 32'h44);
        check_val("bp_pc2", qget(dec_pc, 2), 32'h48);

        rsp_pct = 0;
        n = 0;
        while (memq.size() < 2 && n < 20) begin step(); n++; end
        check_val("two_outst_setup", 32'(memq.size()), 32'h2);
        d0 = stale_drops;
        clear_logs();
        redir_force = 1'b1; redir_target = 32'h100; step(); redir_force = 1'b0;
        rsp_pct = 100;
        repeat (8) step();
        check_val("rd2_addr", qget(acc_log, 0), 32'h100);
        check_val("rd2_first_pc", qget(dec_pc, 0), 32'h100);
        check_val("rd2_drops", 32'(stale_drops - d0), 32'h2);

        redir_force = 1'b1; redir_target = 32'h300; step(); redir_force = 1'b0;
        idr_pct = 0;
        n = 0;
        while (!(expq.size() >= 1 && memq.size() >= 1) && n < 20) begin step(); n++; end
        check_val("rd3_setup", 32'(expq.size() >= 1 && memq.size() >= 1), 32'h1);
        d0 = stale_drops;
        clear_logs();
        idr_pct = 100;
        redir_force = 1'b1; redir_target = 32'h203; step(); redir_force = 1'b0;
        check_val("rd3_hs_count", 32'(dec_pc.size()), 32'h1);
        check_val("rd3_hs_pc", qget(dec_pc, 0), 32'h300);
        check_val("rd3_drops", 32'(stale_drops - d0), 32'h1);
        repeat (6) step();
        check_val("rd3_addr", qget(acc_log, 0), 32'h200);

        clear_logs();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ready_pct = $urandom_range(30, 100);
                idr_pct   = $urandom_range(30, 100);
                rsp_pct   = $urandom_range(30, 100);
                redir_pct = $urandom_range(0, 10);
            end
            rst_req = !(i >= 1500 && i < 1502);
            step();
        end
        check_val("rand_progress", 32'(dec_pc.size() > 100), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
